destruct_sequencer: RTL and testbench



---
 rtl/destruct_sequencer.sv | 159 +++++++++++++++
 tb/tb_destruct_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/destruct_sequencer.sv
// rtl/destruct_sequencer.sv - self-destruct control FSM: arming, 8-step LED countdown, hold, abort, detonation latch
// Optional build macro: DESTRUCT_ABORT_LOCKOUT_EN (ignore abort once 4 or fewer LEDs remain lit)
module destruct_sequencer #(
  parameter int ARM_TICKS   = 50,
  parameter int STEP_TICKS  = 100,
  parameter int BLINK_TICKS = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       in_combat,
  input  logic       danger_vote,
  input  logic       abort_req,
  output logic [7:0] leds,
  output logic [2:0] state,
  output logic       detonate
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MONITOR   = 3'd1,
    S_ARMING    = 3'd2,
    S_COUNTDOWN = 3'd3,
    S_HOLD      = 3'd4,
    S_DETONATED = 3'd5
  } state_t;

  state_t     cur, nxt;
  logic [7:0] bar, bar_n;
  logic       phase, phase_n;
  logic [7:0] arm_cnt, arm_n;
  logic [7:0] step_cnt, step_n;
  logic [7:0] blink_cnt, blink_n;
  logic       abort_locked;
  logic       abort_active;

`ifdef DESTRUCT_ABORT_LOCKOUT_EN
  // Late in the countdown the operator can no longer abort; only combat exit cancels.
  assign abort_locked = ((cur == S_COUNTDOWN) || (cur == S_HOLD)) && (bar <= 8'h0F);
`else
  assign abort_locked = 1'b0;
`endif

  assign abort_active = abort_req && !abort_locked &&
                        ((cur == S_ARMING) || (cur == S_COUNTDOWN) || (cur == S_HOLD));

  // State and counter registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cur       <= S_IDLE;
      bar       <= 8'hFF;
      phase     <= 1'b1;
      arm_cnt   <= 8'd0;
      step_cnt  <= 8'd0;
      blink_cnt <= 8'd0;
    end else begin
      cur       <= nxt;
      bar       <= bar_n;
      phase     <= phase_n;
      arm_cnt   <= arm_n;
      step_cnt  <= step_n;
      blink_cnt <= blink_n;
    end
  end

  // Next-state logic in priority order: detonation latch, combat exit, abort, vote change, tick.
  always_comb begin
    nxt     = cur;
    bar_n   = bar;
    phase_n = phase;
    arm_n   = arm_cnt;
    step_n  = step_cnt;
    blink_n = blink_cnt;
    if (cur == S_DETONATED) begin
      nxt = S_DETONATED;
    end else if (!in_combat || abort_active) begin
      nxt     = in_combat ? S_MONITOR : S_IDLE;
      bar_n   = 8'hFF;
      phase_n = 1'b1;
      arm_n   = 8'd0;
      step_n  = 8'd0;
      blink_n = 8'd0;
    end else begin
      case (cur)
        S_IDLE: nxt = S_MONITOR;
        S_MONITOR: begin
          if (danger_vote) begin
            nxt   = S_ARMING;
            arm_n = 8'd0;
          end
        end
        S_ARMING: begin
          if (!danger_vote) begin
            nxt   = S_MONITOR;
            arm_n = 8'd0;
          end else if (tick) begin
            if (arm_cnt == 8'(ARM_TICKS - 1)) begin
              nxt     = S_COUNTDOWN;
              arm_n   = 8'd0;
              step_n  = 8'd0;
              blink_n = 8'd0;
              phase_n = 1'b1;
            end else begin
              arm_n = arm_cnt + 8'd1;
            end
          end
        end
        S_COUNTDOWN: begin
          if (!danger_vote) begin
            nxt = S_HOLD;
          end else if (tick) begin
            if (blink_cnt == 8'(BLINK_TICKS - 1)) begin
              blink_n = 8'd0;
              phase_n = !phase;
            end else begin
              blink_n = blink_cnt + 8'd1;
            end
            if (step_cnt == 8'(STEP_TICKS - 1)) begin
              step_n = 8'd0;
              bar_n  = bar >> 1;
              if (bar == 8'h01) nxt = S_DETONATED;
            end else begin
              step_n = step_cnt + 8'd1;
            end
          end
        end
        S_HOLD: begin
          if (danger_vote) begin
            nxt     = S_COUNTDOWN;
            phase_n = 1'b1;
          end
        end
        default: begin
          nxt     = S_IDLE;
          bar_n   = 8'hFF;
          phase_n = 1'b1;
          arm_n   = 8'd0;
          step_n  = 8'd0;
          blink_n = 8'd0;
        end
      endcase
    end
  end

  // LED and status decode from the registered state.
  always_comb begin
    leds = 8'h00;
    case (cur)
      S_MONITOR, S_ARMING, S_HOLD: leds = bar;
      S_COUNTDOWN:                 leds = phase ? bar : 8'h00;
      S_DETONATED:                 leds = 8'hFF;
      default:                     leds = 8'h00;
    endcase
  end

  assign state    = cur;
  assign detonate = (cur == S_DETONATED);

endmodule

// File: tb/tb_destruct_sequencer.sv
// tb/tb_destruct_sequencer.sv - self-checking bench for destruct_sequencer with directed scenarios and a random run against a reference model
module tb_destruct_sequencer;

  localparam int ARM   = 2;
  localparam int STEP  = 3;
  localparam int BLINK = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       in_combat = 1'b0;
  logic       danger_vote = 1'b0;
  logic       abort_req = 1'b0;
  logic [7:0] leds;
  logic [2:0] state;
  logic       detonate;

  int checks = 0;
  int failures = 0;

  // Reference model: progress is kept as elapsed tick totals, outputs are derived arithmetically.
  int m_state = 0;
  int m_arm = 0;
  int m_cd = 0;
  int m_bacc = 0;
  int m_base = 0;

  destruct_sequencer #(
    .ARM_TICKS(ARM), .STEP_TICKS(STEP), .BLINK_TICKS(BLINK)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .in_combat(in_combat),
    .danger_vote(danger_vote), .abort_req(abort_req),
    .leds(leds), .state(state), .detonate(detonate)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_bar();
    logic [7:0] full;
    full = 8'hFF;
    if (m_cd >= 8 * STEP) return 8'h00;
    return full >> (m_cd / STEP);
  endfunction

  function automatic logic [7:0] m_leds();
    logic ph;
    ph = (((m_bacc / BLINK) - (m_base / BLINK)) % 2) == 0;
    case (m_state)
      1, 2, 4: return m_bar();
      3:       return ph ? m_bar() : 8'h00;
      5:       return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_clear();
    m_arm = 0; m_cd = 0; m_bacc = 0; m_base = 0;
  endtask

  task automatic model_step(input logic r, input logic t, input logic c, input logic d, input logic a);
    logic locked;
    locked = 1'b0;
    if (!r) begin
      m_state = 0; m_clear();
    end else if (m_state == 5) begin
      m_state = 5;
    end else if (!c) begin
      m_state = 0; m_clear();
    end else begin
`ifdef DESTRUCT_ABORT_LOCKOUT_EN
      locked = (m_state == 3 || m_state == 4) && (m_bar() <= 8'h0F);
`endif
      if (a && m_state >= 2 && m_state <= 4 && !locked) begin
        m_state = 1; m_clear();
      end else begin
        case (m_state)
          0: m_state = 1;
          1: if (d) begin m_state = 2; m_arm = 0; end
          2: begin
            if (!d) begin
              m_state = 1; m_arm = 0;
            end else if (t) begin
              m_arm++;
              if (m_arm == ARM) begin m_state = 3; m_clear(); end
            end
          end
          3: begin
            if (!d) m_state = 4;
            else if (t) begin
              m_cd++; m_bacc++;
              if (m_cd == 8 * STEP) m_state = 5;
            end
          end
          4: if (d) begin m_state = 3; m_base = m_bacc; end
          default: m_state = 0;
        endcase
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, and land 1 time unit after the edge.
  task automatic drive(input logic r, input logic t, input logic c, input logic d, input logic a);
    reset = r; tick = t; in_combat = c; danger_vote = d; abort_req = a;
    model_step(r, t, c, d, a);
    @(posedge clk);
    #1;
  endtask

  task automatic go_countdown();
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0);
    drive(1, 0, 1, 1, 0);
    drive(1, 1, 1, 1, 0);
    drive(1, 1, 1, 1, 0);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (leds !== 8'h00) begin failures++; $display("FAIL reset_leds got=%h exp=00", leds); end
    checks++; if (detonate !== 1'b0) begin failures++; $display("FAIL reset_detonate got=%b exp=0", detonate); end
    drive(1, 0, 1, 0, 0);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL monitor_state got=%0d exp=1", state); end
    checks++; if (leds !== 8'hFF) begin failures++; $display("FAIL monitor_leds got=%h exp=ff", leds); end
  endtask

  task automatic test_countdown();
    logic [7:0] full, exp;
    full = 8'hFF;
    drive(1, 0, 1, 1, 0);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL arming_state got=%0d exp=2", state); end
    drive(1, 1, 1, 1, 0);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL arming_tick1 got=%0d exp=2", state); end
    drive(1, 1, 1, 1, 0);
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL countdown_entry got=%0d exp=3", state); end
    checks++; if (leds !== 8'hFF) begin failures++; $display("FAIL countdown_leds0 got=%h exp=ff", leds); end
    for (int k = 1; k <= 24; k++) begin
      drive(1, 1, 1, 1, 0);
      if (k < 24) begin
        exp = (k % 2 == 0) ? (full >> (k / 3)) : 8'h00;
        checks++; if (leds !== exp) begin failures++; $display("FAIL countdown_leds k=%0d got=%h exp=%h", k, leds, exp); end
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL countdown_state k=%0d got=%0d exp=3", k, state); end
      end
    end
    checks++; if (state !== 3'd5) begin failures++; $display("FAIL detonated_state got=%0d exp=5", state); end
    checks++; if (leds !== 8'hFF) begin failures++; $display("FAIL detonated_leds got=%h exp=ff", leds); end
    checks++; if (detonate !== 1'b1) begin failures++; $display("FAIL detonated_flag got=%b exp=1", detonate); end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 1);
      checks++; if (state !== 3'd5 || detonate !== 1'b1) begin failures++; $display("FAIL detonated_latch got=%0d/%b exp=5/1", state, detonate); end
    end
  endtask

  task automatic test_arming_dropout();
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0);
    drive(1, 0, 1, 1, 0);
    drive(1, 1, 1, 1, 0);
    drive(1, 0, 1, 0, 0);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL dropout_state got=%0d exp=1", state); end
    drive(1, 0, 1, 1, 0);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL rearm_state got=%0d exp=2", state); end
    drive(1, 1, 1, 1, 0);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL rearm_tick1 got=%0d exp=2", state); end
    drive(1, 1, 1, 1, 0);
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL rearm_tick2 got=%0d exp=3", state); end
  endtask

  task automatic test_hold();
    go_countdown();
    for (int i = 0; i < 7; i++) drive(1, 1, 1, 1, 0);
    drive(1, 0, 1, 0, 0);
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL hold_state got=%0d exp=4", state); end
    checks++; if (leds !== 8'h3F) begin failures++; $display("FAIL hold_leds got=%h exp=3f", leds); end
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 1, 0, 0);
      checks++; if (state !== 3'd4 || leds !== 8'h3F) begin failures++; $display("FAIL hold_steady i=%0d got=%0d/%h exp=4/3f", i, state, leds); end
    end
    drive(1, 0, 1, 1, 0);
    checks++; if (state !== 3'd3 || leds !== 8'h3F) begin failures++; $display("FAIL resume got=%0d/%h exp=3/3f", state, leds); end
    drive(1, 1, 1, 1, 0);
    drive(1, 1, 1, 1, 0);
    checks++; if (state !== 3'd3 || leds !== 8'h1F) begin failures++; $display("FAIL resume_step got=%0d/%h exp=3/1f", state, leds); end
  endtask

  task automatic test_abort();
    go_countdown();
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 1, 0);
    drive(1, 0, 1, 1, 1);
    checks++; if (state !== 3'd1 || leds !== 8'hFF) begin failures++; $display("FAIL abort_early got=%0d/%h exp=1/ff", state, leds); end
    drive(1, 0, 1, 1, 0);
    drive(1, 1, 1, 1, 0);
    drive(1, 1, 1, 1, 0);
    for (int i = 0; i < 15; i++) drive(1, 1, 1, 1, 0);
    drive(1, 0, 1, 1, 1);
`ifdef DESTRUCT_ABORT_LOCKOUT_EN
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL abort_locked got=%0d exp=3", state); end
    for (int i = 0; i < 9; i++) drive(1, 1, 1, 1, 1);
    checks++; if (state !== 3'd5 || detonate !== 1'b1) begin failures++; $display("FAIL abort_locked_det got=%0d/%b exp=5/1", state, detonate); end
`else
    checks++; if (state !== 3'd1 || leds !== 8'hFF) begin failures++; $display("FAIL abort_late got=%0d/%h exp=1/ff", state, leds); end
`endif
  endtask

  task automatic test_combat_exit();
    go_countdown();
    for (int i = 0; i < 23; i++) drive(1, 1, 1, 1, 0);
    drive(1, 1, 0, 1, 0);
    checks++; if (state !== 3'd0 || detonate !== 1'b0 || leds !== 8'h00) begin failures++; $display("FAIL combat_exit got=%0d/%b/%h exp=0/0/00", state, detonate, leds); end
    drive(1, 0, 1, 1, 0);
    checks++; if (state !== 3'd1 || leds !== 8'hFF) begin failures++; $display("FAIL combat_exit_bar got=%0d/%h exp=1/ff", state, leds); end
  endtask

  task automatic test_random();
    logic r, t, c, d, a;
    logic [7:0] el;
    d = 1'b0;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      r = !(($urandom_range(0, 599) == 0) || (m_state == 5 && $urandom_range(0, 7) == 0));
      t = $urandom_range(0, 1) == 1;
      c = $urandom_range(0, 149) != 0;
      if ($urandom_range(0, 11) == 0) d = !d;
      a = $urandom_range(0, 39) == 0;
      drive(r, t, c, d, a);
      el = m_leds();
      checks++; if (state !== 3'(m_state)) begin failures++; $display("FAIL rand_state cyc=%0d got=%0d exp=%0d", i, state, m_state); end
      checks++; if (leds !== el) begin failures++; $display("FAIL rand_leds cyc=%0d got=%h exp=%h", i, leds, el); end
      checks++; if (detonate !== (m_state == 5)) begin failures++; $display("FAIL rand_detonate cyc=%0d got=%b exp=%b", i, detonate, m_state == 5); end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_arming_dropout();
    test_hold();
    test_abort();
    test_combat_exit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
